// File: rtl/scanout_fetch.sv
// Scanout pixel source: fetches one frame of RGB words into a line FIFO and drives the DAC.
// Optional colour-bar source is enabled by defining SCANOUT_TEST_PATTERN_EN.
module scanout_fetch #(
    parameter int                H_ACTIVE      = 640,
    parameter int                V_ACTIVE      = 480,
    parameter int                FIFO_DEPTH    = 32,
    parameter int                ADDR_W        = 24,
    parameter logic [ADDR_W-1:0] FB_BASE       = '0,
    parameter logic [23:0]       UNDERFLOW_RGB = 24'hFF00FF,
    localparam int               LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              active,
    input  logic              test_pattern,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        dac_red_pins,
    output logic [7:0]        dac_green_pins,
    output logic [7:0]        dac_blue_pins,
    output logic              underflow,
    output logic [LVL_W-1:0]  fifo_level
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [LVL_W-1:0] outst_q, outst_d;
    logic [LVL_W-1:0] discard_q, discard_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             uf_q;
    logic [23:0]      fifo_mem [FIFO_DEPTH];

    logic             accept, push, pop, empty, full;
    logic [LVL_W:0]   credit;

    // Credit counts in-flight reads so a returning word always has a free slot.
    assign credit   = {1'b0, level_q} + {1'b0, outst_q};
    assign mem_req  = (state_q == S_FETCH) && (issued_q < CNT_W'(TOTAL)) &&
                      (credit < (LVL_W+1)'(FIFO_DEPTH));
    assign mem_addr = FB_BASE + ADDR_W'(issued_q);
    assign accept   = mem_req && mem_ready;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop      = active && !empty;
    assign push     = mem_rvalid && (discard_q == '0) && !full;

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        outst_d   = outst_q + LVL_W'(accept) - LVL_W'(mem_rvalid);
        discard_d = discard_q;
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (mem_rvalid && discard_q != '0)
            discard_d = discard_q - LVL_W'(1);
        if (accept) begin
            issued_d = issued_q + CNT_W'(1);
            if (issued_q == CNT_W'(TOTAL - 1))
                state_d = S_DONE;
        end
        // Resync: everything still in flight (including this cycle's accept) is stale.
        if (frame_start) begin
            state_d   = S_FETCH;
            issued_d  = '0;
            discard_d = outst_d;
            level_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int COL_W = $clog2(H_ACTIVE + 1);

    logic [COL_W-1:0] col_q;
    logic [2:0]       bar;
    logic [23:0]      bar_rgb;

    always_ff @(posedge pixel_clock) begin
        if (reset || !active) col_q <= '0;
        else                  col_q <= col_q + COL_W'(1);
    end

    // Bar index bits map straight onto inverted channel enables: R=~b1, G=~b2, B=~b0.
    assign bar     = 3'(col_q / COL_W'(BAR_W));
    assign bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
`endif

    always_comb begin
        rgb_d = '0;
        if (active)
            rgb_d = empty ? UNDERFLOW_RGB : fifo_mem[rd_ptr_q];
`ifdef SCANOUT_TEST_PATTERN_EN
        if (active && test_pattern)
            rgb_d = bar_rgb;
`endif
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            issued_q  <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rgb_q     <= '0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rgb_q     <= rgb_d;
            if (active && empty)
                uf_q <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (push)
            fifo_mem[wr_ptr_q] <= mem_rdata;
    end

    assert property (@(posedge pixel_clock) disable iff (reset)
        !(mem_rvalid && (discard_q == '0) && full));

    assign dac_red_pins   = rgb_q[23:16];
    assign dac_green_pins = rgb_q[15:8];
    assign dac_blue_pins  = rgb_q[7:0];
    assign underflow      = uf_q;
    assign fifo_level     = level_q;

endmodule

// File: tb/tb_scanout_fetch.sv
// Bench for scanout_fetch: frame-level model (tagged in-order memory, pixel queue) checked every cycle.
module tb_scanout_fetch;
    localparam int H = 16, V = 2, D = 4, AW = 24, TOTAL = H * V;
    localparam logic [23:0] UFC = 24'hFF00FF;
`ifdef SCANOUT_TEST_PATTERN_EN
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, frame_start = 1'b0, active = 1'b0, test_pattern = 1'b0;
    logic mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [23:0] mem_rdata = '0;
    logic mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0] red, green, blue;
    logic underflow;
    logic [2:0] fifo_level;

    scanout_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .pixel_clock(clk), .reset(reset), .frame_start(frame_start), .active(active),
        .test_pattern(test_pattern), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dac_red_pins(red), .dac_green_pins(green), .dac_blue_pins(blue),
        .underflow(underflow), .fifo_level(fifo_level));

    typedef struct {
        logic [23:0] data;
        int          tag;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [23:0] q[$];
    int          epoch = 0, issued = 0, started = 0, run = 0, edge_n = 0, last_due = 0, max_lvl = 0;
    logic [23:0] exp_rgb = '0;
    logic        exp_uf = 1'b0;

    logic nxt_reset = 1'b1, nxt_fs = 1'b0, nxt_active = 1'b0, nxt_tp = 1'b0;
    int   rdy_pct = 100, lat_lo = 1, lat_hi = 1;

    int pass_n = 0, total_n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_n++;
        if (got === want) pass_n++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    // One clock: update model from last cycle's inputs, drive this cycle, compare at negedge.
    task automatic tick();
        req_t        h;
        logic        rv_cur;
        logic [23:0] rv_data;
        int          due;
        @(posedge clk);
        edge_n++;
        if (reset) begin
            pend.delete(); q.delete();
            epoch = 0; issued = 0; started = 0; run = 0; last_due = 0;
            exp_rgb = '0; exp_uf = 1'b0;
        end else begin
            rv_cur = 1'b0; rv_data = '0;
            if (mem_rvalid && pend.size() > 0) begin
                h = pend.pop_front();
                rv_cur = (h.tag == epoch);
                rv_data = h.data;
            end
            if (active) begin
                if (q.size() > 0) exp_rgb = q.pop_front();
                else begin exp_rgb = UFC; exp_uf = 1'b1; end
`ifdef SCANOUT_TEST_PATTERN_EN
                if (test_pattern) exp_rgb = BARS[(run / (H / 8)) % 8];
`endif
                run++;
            end else begin
                exp_rgb = '0; run = 0;
            end
            if (rv_cur) q.push_back(rv_data);
            if (mem_req && mem_ready) begin
                due = edge_n - 1 + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{data: {epoch[7:0], mem_addr[15:0]}, tag: epoch, due: due});
                issued++;
            end
            if (frame_start) begin
                q.delete(); epoch++; issued = 0; started = 1;
            end
        end
        #1;
        reset        = nxt_reset;
        frame_start  = nxt_fs;
        active       = nxt_active;
        test_pattern = nxt_tp;
        mem_ready    = ($urandom_range(99, 0) < rdy_pct);
        if (!nxt_reset && pend.size() > 0 && pend[0].due <= edge_n) begin
            mem_rvalid = 1'b1; mem_rdata = pend[0].data;
        end else begin
            mem_rvalid = 1'b0; mem_rdata = 24'($urandom);
        end
        @(negedge clk);
        chk("mem_req", 32'(mem_req),
            32'(started != 0 && issued < TOTAL && (q.size() + pend.size()) < D));
        chk("mem_addr", 32'(mem_addr), 32'(issued));
        chk("rgb", {8'h0, red, green, blue}, {8'h0, exp_rgb});
        chk("underflow", 32'(underflow), 32'(exp_uf));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    endtask

    initial begin
        int line_left, blank_left;
        repeat (3) tick();
        nxt_reset = 1'b0;
        tick();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_rgb", {8'h0, red, green, blue}, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_uf", 32'(underflow), 0);

        // First frame fill: credit stops at FIFO_DEPTH requests.
        nxt_fs = 1'b1; tick(); nxt_fs = 1'b0;
        repeat (10) tick();
        chk("fill_level", 32'(fifo_level), 4);
        chk("fill_req", 32'(mem_req), 0);
        chk("fill_addr", 32'(mem_addr), 4);

        nxt_active = 1'b1; tick();
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("pop_rgb", {8'h0, red, green, blue}, 32'h010000 + 32'(i - 1));
        end
        nxt_active = 1'b0; tick();
        chk("pop_rgb3", {8'h0, red, green, blue}, 32'h010003);
        tick();
        chk("blank_rgb", {8'h0, red, green, blue}, 0);
        chk("pop_uf", 32'(underflow), 0);

        repeat (6) tick();
        chk("settle_level", 32'(fifo_level), 4);
        chk("settle_addr", 32'(mem_addr), 8);

        // Stall: request must hold with a stable address.
        rdy_pct = 0; nxt_active = 1'b1; tick(); nxt_active = 1'b0;
        repeat (10) tick();
        chk("stall_req", 32'(mem_req), 1);
        chk("stall_addr", 32'(mem_addr), 8);
        chk("stall_level", 32'(fifo_level), 3);

        nxt_active = 1'b1; repeat (5) tick(); nxt_active = 1'b0; tick();
        chk("uf_rgb", {8'h0, red, green, blue}, 32'(UFC));
        chk("uf_flag", 32'(underflow), 1);
        rdy_pct = 100; nxt_fs = 1'b1; tick(); nxt_fs = 1'b0;
        repeat (8) tick();
        chk("uf_sticky", 32'(underflow), 1);

        // Resync with three reads in flight at 5-cycle latency.
        lat_lo = 5; lat_hi = 5;
        nxt_fs = 1'b1; tick(); nxt_fs = 1'b0;
        repeat (3) tick();
        rdy_pct = 0; nxt_fs = 1'b1; tick(); nxt_fs = 1'b0; rdy_pct = 100;
        repeat (25) tick();
        chk("resync_level", 32'(fifo_level), 4);
        chk("resync_max_level", 32'(max_lvl <= 4), 1);
        nxt_active = 1'b1; tick(); tick();
        chk("resync_first", {8'h0, red, green, blue}, 32'h040000);
        nxt_active = 1'b0; tick();
        chk("resync_second", {8'h0, red, green, blue}, 32'h040001);
        lat_lo = 1; lat_hi = 1;
        repeat (4) tick();

`ifdef SCANOUT_TEST_PATTERN_EN
        nxt_tp = 1'b1; nxt_active = 1'b1; tick();
        for (int i = 1; i < H; i++) begin
            tick();
            chk("bar_rgb", {8'h0, red, green, blue}, {8'h0, BARS[(i - 1) / 2]});
        end
        nxt_active = 1'b0; tick();
        chk("bar_last", {8'h0, red, green, blue}, 32'h000000);
        nxt_tp = 1'b0;
        tick();
`endif

        line_left = 0; blank_left = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                rdy_pct = $urandom_range(100, 30);
                lat_lo = 1; lat_hi = $urandom_range(6, 1);
            end
            nxt_fs = ($urandom_range(149, 0) == 0);
            if (line_left == 0 && blank_left == 0) begin
                line_left = H; blank_left = $urandom_range(12, 0);
`ifdef SCANOUT_TEST_PATTERN_EN
                nxt_tp = $urandom_range(1, 0) == 1;
`endif
            end
            if (line_left > 0) begin nxt_active = 1'b1; line_left--; end
            else begin nxt_active = 1'b0; blank_left--; end
            nxt_reset = (c == 2000 || c == 2001);
            tick();
        end
        nxt_active = 1'b0; nxt_fs = 1'b0;
        repeat (3) tick();
        chk("final_max_level", 32'(max_lvl <= D), 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/scanout_fetch.md
Name: scanout_fetch

Overview:
- Pixel-source stage feeding the DAC colour pins in Rush3D. It sits upstream of the DAC and beside HDMIController, whose display-enable and frame strobe it consumes.
- Streams one frame of 24-bit RGB pixels from framebuffer memory over a request/response read port into a line FIFO.
- Pops one pixel per active display cycle and drives registered RGB to the DAC.
- Handles flow control, blanking, underflow and mid-frame resynchronisation.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- FIFO_DEPTH, 32, pixel FIFO entries (power of two, >=4).
- ADDR_W, 24, memory word address width.
- FB_BASE, 0, word address of pixel (0,0); one pixel per word, raster order.
- UNDERFLOW_RGB, 24'hFF00FF, colour emitted on underflow.

Ports:
- pixel_clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at vsync start, from HDMIController.
- active  in  1  display-enable; high for exactly H_ACTIVE cycles per visible line.
- test_pattern  in  1  selects colour bars (used only with the optional feature).
- mem_req  out  1  read request valid.
- mem_addr  out  ADDR_W  read word address.
- mem_ready  in  1  request accepted when mem_req && mem_ready.
- mem_rvalid  in  1  read data valid; responses return in request order, any latency >=1.
- mem_rdata  in  24  {R[23:16],G[15:8],B[7:0]}.
- dac_red_pins / dac_green_pins / dac_blue_pins  out  8 each  registered colour.
- underflow  out  1  sticky: FIFO was empty while active was high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset:
  - mem_req=0, mem_addr=FB_BASE, RGB=0, underflow=0, fifo_level=0.
  - FSM=IDLE; issued, outstanding and discard counters=0.
- FSM IDLE:
  - Waits for frame_start.
  - frame_start -> FETCH; issued=0; FIFO flushed.
- FSM FETCH:
  - mem_req=1 when issued < H_ACTIVE*V_ACTIVE and fifo_level+outstanding < FIFO_DEPTH.
  - mem_addr = FB_BASE + issued, combinational from the registered issued counter.
  - Accept (mem_req && mem_ready): issued+1, outstanding+1.
  - mem_req never drops while waiting on mem_ready unless frame_start or reset occurs.
  - issued reaches the total -> DONE.
- FSM DONE:
  - mem_req=0.
  - frame_start -> FETCH (restart as above).
- Response handling:
  - mem_rvalid decrements outstanding.
  - If discard>0, the data is dropped and discard decrements; otherwise the data is pushed to the FIFO.
  - The credit rule guarantees a push never meets a full FIFO. Push-on-full is a design error: assertion-checked, data dropped.
- frame_start in FETCH/DONE (resync mid-frame):
  - FIFO flushed; discard=outstanding.
  - outstanding is kept so credit stays correct until stale data drains.
  - issued=0; mem_addr returns to FB_BASE the next cycle.
  - An accept in the frame_start cycle counts as stale.
- Output path, latency 1 cycle from active:
  - active && FIFO non-empty: pop; next cycle RGB = popped pixel.
  - active && FIFO empty: no pop; next cycle RGB = UNDERFLOW_RGB; underflow set (sticky until reset).
  - !active: RGB = 0 next cycle.
  - Push and pop in the same cycle: level unchanged. Pop of data pushed the same cycle is not allowed; empty-check uses the pre-push level.
- Frame totals: exactly H_ACTIVE*V_ACTIVE words requested per frame. Active cycles beyond that count underflow.

Optional Feature:
- Macro: SCANOUT_TEST_PATTERN_EN.
- Defined, with test_pattern=1:
  - Memory fetch continues unchanged, and the FIFO pops normally while active.
  - The RGB source is replaced by 8 vertical bars of width H_ACTIVE/8, indexed by an active-pixel column counter that resets when active falls.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black (each channel 8'hFF or 8'h00).
  - Underflow is still flagged, but bar colour is output.
- Not defined: test_pattern is ignored; no column counter or bar logic is synthesised.

Test Plan:
- Reset then frame_start, H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, mem_ready=1, 1-cycle read latency, mem_rdata=address -> exactly 4 requests (addr 0..3), then mem_req=0 until pops; 8 requests total; DONE.
- FIFO prefilled to 4, active high for 4 cycles -> RGB = 0x000000, 0x000001, 0x000002, 0x000003 on the cycles after each active cycle; RGB=0 after active falls; underflow=0.
- mem_ready=0 for 10 cycles during FETCH -> mem_req stays 1, mem_addr stable, no counter change.
- active high with FIFO empty -> RGB=0xFF00FF next cycle; underflow=1 and stays 1 through a later frame_start.
- 3 requests outstanding with 5-cycle read latency, frame_start pulsed -> 3 returning words dropped; first pushed pixel is address FB_BASE; fifo_level never exceeds 4.
- Macro defined, test_pattern=1, H_ACTIVE=16 -> columns 0-1 white, 2-3 0xFFFF00, ..., 14-15 0x000000.
